// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch port.
//   imem_addr  sequencer -> memory  fetch address
//   imem_req   sequencer -> memory  fetch request
//   imem_ack   memory -> sequencer  imem_data valid this cycle
//   imem_data  memory -> sequencer  instruction byte
interface fetch_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_ack;
    logic [7:0]        imem_data;

    modport master (output imem_addr, output imem_req, input imem_ack, input imem_data);
    modport slave  (input imem_addr, input imem_req, output imem_ack, output imem_data);
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch and cycle sequencer for the control decoder.
// Fetches one byte per step over the imem port, holds it in inst, and
// steps the decoder through one (inst[7]=0) or two (inst[7]=1) execute
// phases. Owns pc and the carry flag.
//   clk, rst_n       clock / async active-low reset
//   imem             instruction-memory port (master side)
//   inst, cycle      instruction register and execute phase, to decoder
//   exec             decoder outputs live this clock
//   stall            hold the current execute phase
//   J, jump_target   jump request from control (EXEC1 only)
//   WC, carry_in     carry write from control / ALU
//   carry, pc        carry flag and program counter
module fetch_sequencer #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fetch_sequencer_if.master       imem,
    output logic [7:0]              inst,
    output logic                    cycle,
    output logic                    exec,
    input  logic                    stall,
    input  logic                    J,
    input  logic [ADDR_W-1:0]       jump_target,
    input  logic                    WC,
    input  logic                    carry_in,
    output logic                    carry,
    output logic [ADDR_W-1:0]       pc
);

    typedef enum logic [1:0] {FETCH, EXEC0, EXEC1} state_t;

    state_t state, state_nxt;
    // Low for the first clock after reset so imem_req rises one clock
    // after release rather than combinationally with it.
    logic   started;
    logic   fetch_done;
    logic   jump_take;
    logic   carry_wr;

    // Outputs decode from registers only.
    assign imem.imem_addr = pc;
    assign imem.imem_req  = started && (state == FETCH);
    assign exec           = (state == EXEC0) || (state == EXEC1);
    assign cycle          = (state == EXEC1);

    // An ack only counts while a request is actually outstanding.
    assign fetch_done = imem.imem_req && imem.imem_ack;
    assign jump_take  = (state == EXEC1) && !stall && J;
    assign carry_wr   = exec && !stall && WC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (fetch_done) state_nxt = EXEC0;
            EXEC0:   if (!stall)     state_nxt = inst[7] ? EXEC1 : FETCH;
            EXEC1:   if (!stall)     state_nxt = FETCH;
            default:                 state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
            inst    <= 8'h00;
            pc      <= RESET_PC;
            carry   <= 1'b0;
        end else begin
            started <= 1'b1;
            if (fetch_done) begin
                inst <= imem.imem_data;
                pc   <= pc + ADDR_W'(1);
            end
            // Jump cannot coincide with a fetch (different states), so it
            // simply replaces the increment made at fetch time.
            if (jump_take) pc    <= jump_target;
            if (carry_wr)  carry <= carry_in;
        end
    end

endmodule
